noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Wormhole output-port arbiter for the NoC router/PE link.
- Shares one 20-bit downstream flit channel among N_REQ requesters (local PE injection plus router input ports) with round-robin fairness.
- Holds a grant for the whole packet, head flit through tail flit.
- Enforces credit-based flow control against the downstream input buffer: depth CREDITS, credit returned on ci.

Parameters:
- N_REQ, 4, number of requesters.
- FLIT_W, 20, flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type.
- CREDITS, 4, downstream buffer depth, which is the initial credit count.
- CW, 3, credit counter width; must hold CREDITS.

Ports:
- clk, input, 1: clock, rising edge.
- RST, input, 1: reset, asynchronous, active-low.
- req_valid, input, N_REQ: per-requester flit valid.
- req_flit, input, N_REQ*FLIT_W: per-requester flit; requester i occupies slice [i*FLIT_W +: FLIT_W].
- req_ready, output, N_REQ: flit of requester i is accepted this cycle.
- ci, input, 1: credit return pulse, one slot freed downstream.
- dataout, output, FLIT_W: registered output flit.
- out_valid, output, 1: dataout valid for one cycle.
- grant_id, output, 2: current or last granted requester.
- locked, output, 1: a packet is in progress.
- credit_cnt, output, CW: available credits.
- credit_err, output, 1: sticky; set when ci arrives with credit_cnt == CREDITS.

Behaviour:
- Flit type encoding [19:18]:
  - 2'b10 = head
  - 2'b00 = body
  - 2'b01 = tail
  - 2'b11 = single-flit packet (head and tail)
- Reset values:
  - dataout = 0, out_valid = 0, grant_id = 0, locked = 0
  - credit_cnt = CREDITS, credit_err = 0
  - rr pointer = 0, FSM in IDLE
- Reset mid-packet aborts the packet with no tail emitted. Recovery is the upstream's responsibility.
- FSM states: IDLE and LOCKED.
- IDLE:
  - Candidates are the requesters with req_valid=1 and a head or single flit type.
  - Valid requesters presenting body or tail flits are ignored: ready=0, and the bench flags this as a protocol error.
  - Winner = first candidate at or after rr_ptr, searching in increasing index with wrap-around.
  - Grant occurs only if credit_cnt > 0.
  - req_ready[winner] = 1 combinationally that cycle; all other ready bits are 0.
  - On a head transfer: go to LOCKED with owner = winner, and set grant_id = winner.
  - On a single-flit transfer: stay in IDLE, set rr_ptr = winner+1 mod N_REQ, and set grant_id = winner.
- LOCKED:
  - req_ready[owner] = req_valid[owner] && credit_cnt > 0; all others are 0.
  - Body flits keep LOCKED.
  - A tail transfer goes to IDLE and sets rr_ptr = owner+1 mod N_REQ.
  - A head or single flit from the owner while LOCKED is still forwarded, and the FSM stays LOCKED. The bench flags it.
- Transfer: occurs when req_valid[i] && req_ready[i]. On the next rising edge, dataout = that flit and out_valid = 1.
  - Latency is exactly 1 cycle.
  - out_valid = 0 in cycles with no transfer; dataout holds its last value.
- Credits:
  - Decrement on transfer; increment on ci.
  - Transfer and ci in the same cycle leave the count unchanged.
  - credit_cnt never goes below 0, because no transfer is possible at 0.
  - ci at CREDITS with no same-cycle transfer: count stays at CREDITS and credit_err is set. Only reset clears credit_err.
- Throughput: one flit per cycle while credits last.
  - With CREDITS=4 and no ci, at most 4 back-to-back flits, then stall.
  - Stall is not a bubble in the grant: the lock is retained.
- Stability: the winner is computed from registered rr_ptr and the FSM state. There is no combinational path from ci to req_ready; ci affects credits only at the next edge.

Decomposition:
- Shared package or include noc_defs:
  - FLIT_W
  - flit type localparams: FT_HEAD=2'b10, FT_BODY=2'b00, FT_TAIL=2'b01, FT_SINGLE=2'b11
  - default CREDITS
- Sub-module rr_arbiter (N_REQ): purely combinational one-hot grant from a request vector and rr_ptr, plus a valid flag.
- The credit counter and FSM live in the top level.

Test Plan:
1. Reset then idle: after RST deassert, credit_cnt=4, out_valid=0, req_ready=0000.
2. Single requester 0 sends 3-flit packet 0x80001, 0x00002, 0x40003 with no ci: dataout follows with 1-cycle latency; credit_cnt goes 4→3→2→1; locked goes high after the head and clears after the tail.
3. Requesters 1 and 2 both present heads, rr_ptr=0: 1 is granted first; while 1 is locked, 2's ready stays 0; after 1's tail, 2 is granted; rr_ptr=3 afterwards.
4. Credit exhaustion: a 6-flit packet with no ci stalls after 4 flits with ready=0 and the lock kept. A ci pulse gives exactly one more flit. ci coincident with a transfer leaves credit_cnt unchanged.
5. Credit overflow: ci pulsed at credit_cnt=4 → credit_cnt stays 4, credit_err=1 and stays 1.
6. Async reset asserted mid-packet (LOCKED, credit_cnt=1) → immediate state LOCKED=0, credit_cnt=4, out_valid=0. The next single flit 0xC00AA from requester 3 is accepted and forwarded normally.

Source files
------------

// File: rtl/noc_output_arbiter_pkg.sv
// noc_output_arbiter_pkg: flit format, FSM encoding and defaults shared by the output-port arbiter.
package noc_output_arbiter_pkg;
   localparam int NOC_FLIT_W  = 20;
   localparam int DEF_CREDITS = 4;
   localparam logic [1:0] FT_HEAD   = 2'b10;
   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_TAIL   = 2'b01;
   localparam logic [1:0] FT_SINGLE = 2'b11;
   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_LOCKED = 1'b1;
   function automatic logic opens_packet(input logic [1:0] ft);
      return ft == FT_HEAD || ft == FT_SINGLE;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, with wrap-around.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    gnt_id,
   output logic             any
);
   int idx;
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      idx    = 0;
      any    = |req;
      // farthest offset first so the nearest request overwrites it last
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) begin
            gnt    = N_REQ'(1) << idx;
            gnt_id = PW'(idx);
         end
      end
   end
endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: wormhole round-robin output-port arbiter with credit-based flow control.
module noc_output_arbiter
   import noc_output_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int FLIT_W  = NOC_FLIT_W,
   parameter int CREDITS = DEF_CREDITS,
   parameter int CW      = 3,
   parameter int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*FLIT_W-1:0] req_flit,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    ci,
   output logic [FLIT_W-1:0]       dataout,
   output logic                    out_valid,
   output logic [PW-1:0]           grant_id,
   output logic                    locked,
   output logic [CW-1:0]           credit_cnt,
   output logic                    credit_err
);
   logic              state;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     arb_id;
   logic [PW-1:0]     sel_id;
   logic [N_REQ-1:0]  cand;
   logic [N_REQ-1:0]  arb_gnt;
   logic              arb_any;
   logic              has_credit;
   logic              xfer;
   logic [FLIT_W-1:0] flits [N_REQ];
   logic [FLIT_W-1:0] sel_flit;
   logic [1:0]        sel_type;

   if (CREDITS >= (1 << CW)) begin : g_bad_cw
      $error("CW too narrow to hold CREDITS");
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign flits[i] = req_flit[i*FLIT_W +: FLIT_W];
      assign cand[i]  = req_valid[i] && opens_packet(flits[i][FLIT_W-1 -: 2]);
   end

   rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
      .req    (cand),
      .ptr    (rr_ptr),
      .gnt    (arb_gnt),
      .gnt_id (arb_id),
      .any    (arb_any)
   );

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] id);
      return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   // ready depends only on registered state and req_valid/req_flit, never on ci
   assign has_credit = credit_cnt != '0;
   assign locked     = state == ST_LOCKED;
   assign sel_id     = locked ? owner : arb_id;
   assign sel_flit   = flits[sel_id];
   assign sel_type   = sel_flit[FLIT_W-1 -: 2];
   assign req_ready  = !has_credit ? '0 :
                       locked      ? (req_valid & (N_REQ'(1) << owner)) :
                       arb_any     ? arb_gnt : '0;
   assign xfer       = |(req_valid & req_ready);

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state    <= ST_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         grant_id <= '0;
      end else if (xfer) begin
         if (!locked) begin
            grant_id <= sel_id;
            if (sel_type == FT_HEAD) begin
               state <= ST_LOCKED;
               owner <= sel_id;
            end else begin
               rr_ptr <= next_ptr(sel_id);
            end
         end else if (sel_type == FT_TAIL) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr(owner);
         end
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         dataout    <= '0;
         out_valid  <= 1'b0;
         credit_cnt <= CW'(CREDITS);
         credit_err <= 1'b0;
      end else begin
         out_valid <= xfer;
         if (xfer)
            dataout <= sel_flit;
         if (xfer && !ci)
            credit_cnt <= credit_cnt - 1'b1;
         else if (!xfer && ci) begin
            if (credit_cnt == CW'(CREDITS))
               credit_err <= 1'b1;
            else
               credit_cnt <= credit_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: directed and randomized checks of the output arbiter against a flit-level reference model.
module tb_noc_output_arbiter;
   import noc_output_arbiter_pkg::*;
   localparam int N = 4, W = 20, CR = 4;

   logic         clk = 1'b0;
   logic         RST = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N*W-1:0] req_flit = '0;
   logic         ci = 1'b0;
   logic [N-1:0] req_ready;
   logic [W-1:0] dataout;
   logic         out_valid;
   logic [1:0]   grant_id;
   logic         locked;
   logic [2:0]   credit_cnt;
   logic         credit_err;

   int n_cmp = 0, n_bad = 0, n_proto = 0;
   bit m_locked, m_err, m_ov;
   int m_owner, m_ptr, m_cred, m_gid;
   logic [W-1:0] m_dout;
   logic [N-1:0] exp_ready, obs_ready;

   always #5 clk = ~clk;

   noc_output_arbiter dut (
      .clk(clk), .RST(RST), .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
      .ci(ci), .dataout(dataout), .out_valid(out_valid), .grant_id(grant_id), .locked(locked),
      .credit_cnt(credit_cnt), .credit_err(credit_err)
   );

   function automatic logic [W-1:0] slot(input logic [N*W-1:0] f, input int i);
      return f[i*W +: W];
   endfunction

   function automatic logic [N*W-1:0] put(input int i, input logic [W-1:0] fl);
      logic [N*W-1:0] v = '0;
      v[i*W +: W] = fl;
      return v;
   endfunction

   function automatic bit starts(input logic [W-1:0] fl);
      return fl[W-1:W-2] == FT_HEAD || fl[W-1:W-2] == FT_SINGLE;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_err = 0; m_ov = 0; m_owner = 0; m_ptr = 0; m_cred = CR; m_gid = 0; m_dout = '0;
   endtask

   // packet-level rules: who may send this cycle
   function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic [N*W-1:0] f);
      if (m_cred == 0) return '0;
      if (m_locked) return v[m_owner] ? N'(1) << m_owner : '0;
      for (int k = 0; k < N; k++) begin
         int i = (m_ptr + k) % N;
         if (v[i] && starts(slot(f, i))) return N'(1) << i;
      end
      return '0;
   endfunction

   task automatic model_step(input logic [N-1:0] v, input logic [N*W-1:0] f, input logic c, input logic [N-1:0] rdy);
      int w = -1;
      for (int i = 0; i < N; i++) if (rdy[i] && v[i]) w = i;
      m_ov = w >= 0;
      if (w >= 0) begin
         logic [W-1:0] fl = slot(f, w);
         m_dout = fl;
         if (!m_locked) begin
            m_gid = w;
            if (fl[W-1:W-2] == FT_HEAD) begin m_locked = 1; m_owner = w; end
            else m_ptr = (w + 1) % N;
         end else if (fl[W-1:W-2] == FT_TAIL) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
         end
      end
      if (w >= 0 && !c) m_cred = m_cred - 1;
      else if (w < 0 && c) begin
         if (m_cred == CR) m_err = 1;
         else m_cred = m_cred + 1;
      end
   endtask

   // called at posedge+1; samples ready mid-cycle, returns at next posedge+1
   task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] f, input logic c);
      req_valid = v; req_flit = f; ci = c;
      #3;
      exp_ready = model_ready(v, f);
      obs_ready = req_ready;
      for (int i = 0; i < N; i++) begin
         logic [W-1:0] fl = slot(f, i);
         if (v[i] && !m_locked && !starts(fl)) n_proto++;
         if (v[i] && m_locked && i == m_owner && starts(fl)) n_proto++;
      end
      @(posedge clk);
      model_step(v, f, c, exp_ready);
      #1;
      req_valid = '0; ci = 1'b0;
   endtask

   task automatic do_reset();
      req_valid = '0; ci = 1'b0;
      @(negedge clk); RST = 1'b0;
      model_reset();
      @(negedge clk); RST = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (credit_cnt !== 3'd4) begin n_bad++; $display("FAIL reset_credit: got %0d want 4", credit_cnt); end
      n_cmp++; if (out_valid !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("FAIL reset_flags: out_valid=%b locked=%b want 0 0", out_valid, locked); end
      n_cmp++; if (dataout !== '0 || grant_id !== 2'd0 || credit_err !== 1'b0) begin n_bad++; $display("FAIL reset_regs: dataout=%h grant=%0d err=%b want 0", dataout, grant_id, credit_err); end
      cycle('0, '0, 1'b0);
      n_cmp++; if (obs_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
   endtask

   task automatic test_single_packet();
      logic [W-1:0] pkt [3] = '{20'h80001, 20'h00002, 20'h40003};
      for (int k = 0; k < 3; k++) begin
         cycle(4'b0001, put(0, pkt[k]), 1'b0);
         n_cmp++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL sp_ready[%0d]: got %b want 0001", k, obs_ready); end
         n_cmp++; if (dataout !== pkt[k] || out_valid !== 1'b1) begin n_bad++; $display("FAIL sp_data[%0d]: got %h/%b want %h/1", k, dataout, out_valid, pkt[k]); end
         n_cmp++; if (credit_cnt !== 3'(3 - k)) begin n_bad++; $display("FAIL sp_credit[%0d]: got %0d want %0d", k, credit_cnt, 3 - k); end
         n_cmp++; if (locked !== (k < 2)) begin n_bad++; $display("FAIL sp_lock[%0d]: got %b want %b", k, locked, k < 2); end
      end
      cycle('0, '0, 1'b0);
      n_cmp++; if (out_valid !== 1'b0 || dataout !== 20'h40003) begin n_bad++; $display("FAIL sp_hold: got %h/%b want 40003/0", dataout, out_valid); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0]   v_t [6] = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b1001};
      logic [N*W-1:0] f_t [6];
      logic [N-1:0]   r_t [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
      logic [1:0]     g_t [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
      logic           l_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      f_t[0] = put(1, 20'h80011) | put(2, 20'h80021);
      f_t[1] = put(1, 20'h00012) | put(2, 20'h80021);
      f_t[2] = put(1, 20'h40013) | put(2, 20'h80021);
      f_t[3] = put(2, 20'h80021);
      f_t[4] = put(2, 20'h40022);
      f_t[5] = put(0, 20'hC0001) | put(3, 20'hC0031);
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle(v_t[k], f_t[k], 1'b1);
         n_cmp++; if (obs_ready !== r_t[k]) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, obs_ready, r_t[k]); end
         n_cmp++; if (grant_id !== g_t[k] || locked !== l_t[k]) begin n_bad++; $display("FAIL rr_state[%0d]: grant=%0d locked=%b want %0d %b", k, grant_id, locked, g_t[k], l_t[k]); end
      end
      n_cmp++; if (dataout !== 20'hC0031 || credit_cnt !== 3'd4 || credit_err !== 1'b0) begin n_bad++; $display("FAIL rr_end: data=%h credit=%0d err=%b want C0031 4 0", dataout, credit_cnt, credit_err); end
   endtask

   task automatic test_credit_exhaust();
      logic [W-1:0] p [6] = '{20'h80100, 20'h00101, 20'h00102, 20'h00103, 20'h00104, 20'h40105};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(4'b0001, put(0, p[k]), 1'b0);
         n_cmp++; if (obs_ready !== 4'b0001 || dataout !== p[k] || credit_cnt !== 3'(3 - k)) begin n_bad++; $display("FAIL ce_burst[%0d]: ready=%b data=%h credit=%0d want 0001 %h %0d", k, obs_ready, dataout, credit_cnt, p[k], 3 - k); end
      end
      cycle(4'b0001, put(0, p[4]), 1'b0);
      n_cmp++; if (obs_ready !== 4'b0000 || locked !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ce_stall: ready=%b locked=%b ov=%b want 0000 1 0", obs_ready, locked, out_valid); end
      cycle(4'b0001, put(0, p[4]), 1'b1);
      n_cmp++; if (obs_ready !== 4'b0000 || credit_cnt !== 3'd1) begin n_bad++; $display("FAIL ce_ci: ready=%b credit=%0d want 0000 1", obs_ready, credit_cnt); end
      cycle(4'b0001, put(0, p[4]), 1'b0);
      n_cmp++; if (obs_ready !== 4'b0001 || dataout !== p[4] || credit_cnt !== 3'd0) begin n_bad++; $display("FAIL ce_one: ready=%b data=%h credit=%0d want 0001 %h 0", obs_ready, dataout, credit_cnt, p[4]); end
      cycle(4'b0001, put(0, p[5]), 1'b0);
      n_cmp++; if (obs_ready !== 4'b0000) begin n_bad++; $display("FAIL ce_only_one: ready=%b want 0000", obs_ready); end
      cycle(4'b0001, put(0, p[5]), 1'b1);
      cycle(4'b0001, put(0, p[5]), 1'b1);
      n_cmp++; if (obs_ready !== 4'b0001 || credit_cnt !== 3'd1 || dataout !== p[5] || locked !== 1'b0) begin n_bad++; $display("FAIL ce_coincide: ready=%b credit=%0d data=%h locked=%b want 0001 1 %h 0", obs_ready, credit_cnt, dataout, locked, p[5]); end
   endtask

   task automatic test_credit_overflow();
      do_reset();
      cycle('0, '0, 1'b1);
      n_cmp++; if (credit_cnt !== 3'd4 || credit_err !== 1'b1) begin n_bad++; $display("FAIL ov_set: credit=%0d err=%b want 4 1", credit_cnt, credit_err); end
      cycle('0, '0, 1'b0);
      cycle(4'b0100, put(2, 20'hC0200), 1'b1);
      n_cmp++; if (credit_err !== 1'b1 || credit_cnt !== 3'd4 || dataout !== 20'hC0200) begin n_bad++; $display("FAIL ov_sticky: err=%b credit=%0d data=%h want 1 4 C0200", credit_err, credit_cnt, dataout); end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(4'b0001, put(0, 20'h80300), 1'b0);
      cycle(4'b0001, put(0, 20'h00301), 1'b0);
      cycle(4'b0001, put(0, 20'h00302), 1'b0);
      n_cmp++; if (locked !== 1'b1 || credit_cnt !== 3'd1) begin n_bad++; $display("FAIL ar_pre: locked=%b credit=%0d want 1 1", locked, credit_cnt); end
      #2 RST = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (locked !== 1'b0 || credit_cnt !== 3'd4 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_now: locked=%b credit=%0d ov=%b want 0 4 0", locked, credit_cnt, out_valid); end
      @(negedge clk); RST = 1'b1;
      @(posedge clk); #1;
      cycle(4'b1000, put(3, 20'hC00AA), 1'b0);
      n_cmp++; if (obs_ready !== 4'b1000 || dataout !== 20'hC00AA || out_valid !== 1'b1 || grant_id !== 2'd3) begin n_bad++; $display("FAIL ar_after: ready=%b data=%h ov=%b grant=%0d want 1000 C00AA 1 3", obs_ready, dataout, out_valid, grant_id); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [N-1:0] v = N'($urandom);
         logic [N*W-1:0] f = '0;
         logic c;
         for (int i = 0; i < N; i++) f[i*W +: W] = W'($urandom);
         c = ($urandom_range(0, 2) == 0) && (m_cred < CR || $urandom_range(0, 19) == 0);
         cycle(v, f, c);
         n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", n, obs_ready, exp_ready); end
         n_cmp++; if (out_valid !== m_ov || (m_ov && dataout !== m_dout)) begin n_bad++; $display("FAIL rnd_out@%0d: got %h/%b want %h/%b", n, dataout, out_valid, m_dout, m_ov); end
         n_cmp++; if (grant_id !== 2'(m_gid) || locked !== m_locked) begin n_bad++; $display("FAIL rnd_grant@%0d: grant=%0d locked=%b want %0d %b", n, grant_id, locked, m_gid, m_locked); end
         n_cmp++; if (credit_cnt !== 3'(m_cred) || credit_err !== m_err) begin n_bad++; $display("FAIL rnd_credit@%0d: credit=%0d err=%b want %0d %b", n, credit_cnt, credit_err, m_cred, m_err); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_credit_exhaust();
      test_credit_overflow();
      test_async_reset();
      test_random();
      $display("protocol violations presented by stimulus: %0d", n_proto);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
